// File: rtl/bus_arbiter.sv
// Shares the 6502 memory bus between CPU and one DMA master; grant 1 cycle after a qualifying request, 1-cycle RECOVER turnaround.
// The CPU is stalled via cpu_rdy while the DMA owns the bus; optional stall counter under ARB_STALL_COUNT_EN.
module bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CPU_MIN   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic        cpu_read_write,
    input  logic [7:0]  cpu_data_write,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic        dma_read_write,
    input  logic [7:0]  dma_data_write,
    output logic        dma_gnt,
    output logic        dma_ack,
`ifdef ARB_STALL_COUNT_EN
    output logic [15:0] stall_cycles,
`endif
    output logic [15:0] mem_address,
    output logic        mem_read_write,
    output logic [7:0]  mem_data_write
);

    localparam int BW = ($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam int GW = ($clog2(CPU_MIN + 1) > 1) ? $clog2(CPU_MIN + 1) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GAP_MIN    = GW'(CPU_MIN);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DMA     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [GW-1:0] gap_q, gap_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CPU;
            burst_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        burst_d        = burst_q;
        gap_d          = gap_q;
        cpu_rdy        = 1'b1;
        dma_gnt        = 1'b0;
        mem_address    = cpu_address;
        mem_read_write = cpu_read_write;
        mem_data_write = cpu_data_write;
        case (state_q)
            ST_CPU: begin
                if (gap_q < GAP_MIN) gap_d = gap_q + 1'b1;
                // A CPU write cycle is never stolen; only read cycles can hand over.
                if (dma_req && cpu_read_write && (gap_q >= GAP_MIN)) state_d = ST_DMA;
            end
            ST_DMA: begin
                cpu_rdy        = 1'b0;
                dma_gnt        = 1'b1;
                mem_address    = dma_address;
                mem_read_write = dma_read_write;
                mem_data_write = dma_data_write;
                if (dma_req) begin
                    burst_d = burst_q + 1'b1;
                    if (burst_q == BURST_LAST) state_d = ST_RECOVER;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                // Hold the bus in a harmless read while the CPU takes its outputs back.
                cpu_rdy        = 1'b0;
                mem_read_write = 1'b1;
                mem_data_write = 8'h00;
                burst_d        = '0;
                gap_d          = '0;
                state_d        = ST_CPU;
            end
            default: state_d = ST_CPU;
        endcase
    end

    assign dma_ack = dma_gnt & dma_req;

`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 16'd0;
        end else if (!cpu_rdy && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with default parameters and a behavioural async-read memory.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_address;
    logic        cpu_read_write;
    logic [7:0]  cpu_data_write;
    logic        cpu_rdy;
    logic        dma_req;
    logic [15:0] dma_address;
    logic        dma_read_write;
    logic [7:0]  dma_data_write;
    logic        dma_gnt;
    logic        dma_ack;
    logic [15:0] mem_address;
    logic        mem_read_write;
    logic [7:0]  mem_data_write;
`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    int acks;

    logic [7:0] mem [0:65535];

    bus_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_address    (cpu_address),
        .cpu_read_write (cpu_read_write),
        .cpu_data_write (cpu_data_write),
        .cpu_rdy        (cpu_rdy),
        .dma_req        (dma_req),
        .dma_address    (dma_address),
        .dma_read_write (dma_read_write),
        .dma_data_write (dma_data_write),
        .dma_gnt        (dma_gnt),
        .dma_ack        (dma_ack),
`ifdef ARB_STALL_COUNT_EN
        .stall_cycles   (stall_cycles),
`endif
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_write (mem_data_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_read_write) mem[mem_address] <= mem_data_write;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Counts rising edges until dma_gnt appears (bounded).
    task automatic wait_gnt(output int cnt);
        cnt = 0;
        while (!dma_gnt && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    // Counts acks while granted; returns in the first non-granted cycle.
    task automatic count_acks(output int a);
        int guard;
        a = 0;
        guard = 0;
        while (dma_gnt && guard < 40) begin
            if (dma_ack) a++;
            tick();
            guard++;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst            = 1'b1;
        cpu_address    = 16'h1234;
        cpu_read_write = 1'b1;
        cpu_data_write = 8'h55;
        dma_req        = 1'b0;
        dma_address    = 16'hBEEF;
        dma_read_write = 1'b1;
        dma_data_write = 8'h3C;
        #1 rst = 1'b0;
        #11;
        chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_mem_addr", 32'(mem_address), 32'h1234);
`ifdef ARB_STALL_COUNT_EN
        chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif

        // Held request with CPU reading: gap counts 0..4, grant on the 5th edge.
        @(negedge clk);
        rst     = 1'b1;
        dma_req = 1'b1;
        wait_gnt(n);
        chk("first_grant_edges", 32'(n), 32'd5);
        chk("dma_mem_addr", 32'(mem_address), 32'hBEEF);
        chk("dma_cpu_rdy", 32'(cpu_rdy), 32'd0);
        count_acks(acks);
        chk("burst_acks", 32'(acks), 32'd16);
        chk("recover_cpu_rdy", 32'(cpu_rdy), 32'd0);
        chk("recover_rw", 32'(mem_read_write), 32'd1);
        chk("recover_wdata", 32'(mem_data_write), 32'd0);
        chk("recover_addr", 32'(mem_address), 32'h1234);
        tick();
        chk("resume_cpu_rdy", 32'(cpu_rdy), 32'd1);
        wait_gnt(n);
        chk("regrant_edges", 32'(n), 32'd5);
        dma_req = 1'b0;
        #1;
        chk("drop_req_ack", 32'(dma_ack), 32'd0);
        chk("drop_req_gnt", 32'(dma_gnt), 32'd1);
        tick();
        chk("drop_recover_gnt", 32'(dma_gnt), 32'd0);
        chk("drop_recover_rdy", 32'(cpu_rdy), 32'd0);
        tick();

        // Request during CPU writes waits for the first CPU read.
        idle(6);
        cpu_read_write = 1'b0;
        cpu_data_write = 8'h77;
        dma_req        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("write_no_steal", 32'(dma_gnt), 32'd0);
        end
        cpu_read_write = 1'b1;
        tick();
        chk("grant_after_read", 32'(dma_gnt), 32'd1);
        dma_req = 1'b0;
        tick();
        tick();

        // DMA writes A5 to 0200..0202 then drops the request.
        idle(6);
        dma_req        = 1'b1;
        dma_read_write = 1'b0;
        dma_data_write = 8'hA5;
        dma_address    = 16'h0200;
        tick();
        chk("wr_grant", 32'(dma_gnt), 32'd1);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                dma_req     = 1'b1;
                dma_address = 16'h0200 + 16'(k);
            end else begin
                dma_req = 1'b0;
            end
            #1;
            if (dma_ack) acks++;
            tick();
        end
        chk("wr_acks", 32'(acks), 32'd3);
        chk("wr_recover_gnt", 32'(dma_gnt), 32'd0);
        chk("wr_recover_rdy", 32'(cpu_rdy), 32'd0);
        chk("mem_01ff", 32'(mem[16'h01FF]), 32'h00);
        chk("mem_0200", 32'(mem[16'h0200]), 32'hA5);
        chk("mem_0201", 32'(mem[16'h0201]), 32'hA5);
        chk("mem_0202", 32'(mem[16'h0202]), 32'hA5);
        chk("mem_0203", 32'(mem[16'h0203]), 32'h00);
        chk("mem_1234", 32'(mem[16'h1234]), 32'h77);
        tick();
        dma_read_write = 1'b1;
        dma_address    = 16'hBEEF;

        // Reset during the 5th transfer, then the gap restarts from zero.
        idle(6);
        dma_req = 1'b1;
        tick();
        idle(4);
        chk("pre_rst_gnt", 32'(dma_gnt), 32'd1);
        chk("pre_rst_ack", 32'(dma_ack), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_gnt", 32'(dma_gnt), 32'd0);
        chk("midrst_ack", 32'(dma_ack), 32'd0);
        chk("midrst_rdy", 32'(cpu_rdy), 32'd1);
        chk("midrst_addr", 32'(mem_address), 32'h1234);
        @(negedge clk);
        rst = 1'b1;
        wait_gnt(n);
        chk("post_rst_grant_edges", 32'(n), 32'd5);
        count_acks(acks);
        chk("post_rst_acks", 32'(acks), 32'd16);
        tick();
`ifdef ARB_STALL_COUNT_EN
        chk("stall_full_burst", 32'(stall_cycles), 32'd17);
`endif
        dma_req = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
